// File: rtl/dp_tl_pkg.sv
// Shared transaction-layer definitions for the DPCD sink responder.
// Holds bus widths, reply/command codes and the DPCD region map.
package dp_tl_pkg;

  localparam int unsigned AUX_ADDRESS_WIDTH = 20;
  localparam int unsigned AUX_DATA_WIDTH    = 8;

  typedef enum logic [1:0] {
    REPLY_ACK   = 2'b00,
    REPLY_NACK  = 2'b01,
    REPLY_DEFER = 2'b10
  } reply_e;

  typedef enum logic [1:0] {
    CMD_WRITE = 2'b00,
    CMD_READ  = 2'b01
  } cmd_e;

  localparam logic [AUX_ADDRESS_WIDTH-1:0] CAP_BASE  = 20'h00000;
  localparam logic [AUX_ADDRESS_WIDTH-1:0] CFG_BASE  = 20'h00100;
  localparam logic [AUX_ADDRESS_WIDTH-1:0] STAT_BASE = 20'h00200;

  typedef enum logic [1:0] {
    RGN_CAP,
    RGN_CFG,
    RGN_STAT,
    RGN_NONE
  } region_e;

  // Each region is 16 bytes, so only the address bits above the byte offset matter.
  function automatic region_e decode_region(input logic [AUX_ADDRESS_WIDTH-1:0] addr);
    if (addr[AUX_ADDRESS_WIDTH-1:4] == CAP_BASE[AUX_ADDRESS_WIDTH-1:4])  return RGN_CAP;
    if (addr[AUX_ADDRESS_WIDTH-1:4] == CFG_BASE[AUX_ADDRESS_WIDTH-1:4])  return RGN_CFG;
    if (addr[AUX_ADDRESS_WIDTH-1:4] == STAT_BASE[AUX_ADDRESS_WIDTH-1:4]) return RGN_STAT;
    return RGN_NONE;
  endfunction

endpackage

// File: rtl/dp_dpcd_regfile.sv
// DPCD register file: capability constants, read/write link config, mirrored status.
// Presents a whole 16-byte region view and commits multi-byte writes in one cycle.
module dp_dpcd_regfile
  import dp_tl_pkg::*;
#(
  parameter logic [7:0] DPCD_REV       = 8'h12,
  parameter logic [7:0] MAX_LINK_RATE  = 8'h1E,
  parameter logic [7:0] MAX_LANE_COUNT = 8'h84
) (
  input  logic                                clk,
  input  logic                                rst,
  input  region_e                             rgn_i,
  input  logic                                wr_en_i,
  input  logic [3:0]                          wr_ofs_i,
  input  logic [3:0]                          wr_last_i,
  input  logic [15:0][AUX_DATA_WIDTH-1:0]     wr_buf_i,
  input  logic [15:0]                         lane_status_i,
  input  logic [7:0]                          lane_align_i,
  output logic [15:0][AUX_DATA_WIDTH-1:0]     view_o,
  output logic [7:0]                          link_bw_o,
  output logic [4:0]                          lane_count_o,
  output logic [7:0]                          training_pattern_o
);

  logic [15:0][AUX_DATA_WIDTH-1:0] cfg_q;

  // Byte k of the burst lands at offset+k; only the config region is writable.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_q <= '0;
    end else if (wr_en_i && (rgn_i == RGN_CFG)) begin
      for (int unsigned k = 0; k < 16; k++) begin
        if (4'(k) <= wr_last_i) cfg_q[wr_ofs_i + 4'(k)] <= wr_buf_i[k];
      end
    end
  end

  always_comb begin
    view_o = '0;
    unique case (rgn_i)
      RGN_CAP: begin
        view_o[0] = DPCD_REV;
        view_o[1] = MAX_LINK_RATE;
        view_o[2] = MAX_LANE_COUNT;
      end
      RGN_CFG: view_o = cfg_q;
      RGN_STAT: begin
        view_o[2] = lane_status_i[7:0];
        view_o[3] = lane_status_i[15:8];
        view_o[4] = lane_align_i;
      end
      default: ;
    endcase
  end

  assign link_bw_o          = cfg_q[0];
  assign lane_count_o       = cfg_q[1][4:0];
  assign training_pattern_o = cfg_q[2];

endmodule

// File: rtl/dp_sink_dpcd_responder.sv
// Sink-side native AUX responder: captures a request, runs it against the DPCD
// register file and returns ACK/NACK/DEFER plus read bytes after a turnaround.
module dp_sink_dpcd_responder
  import dp_tl_pkg::*;
#(
  parameter int unsigned AUX_ADDRESS_WIDTH = dp_tl_pkg::AUX_ADDRESS_WIDTH,
  parameter int unsigned AUX_DATA_WIDTH    = dp_tl_pkg::AUX_DATA_WIDTH,
  parameter int unsigned REPLY_DELAY       = 4,
  parameter logic [7:0]  DPCD_REV          = 8'h12,
  parameter logic [7:0]  MAX_LINK_RATE     = 8'h1E,
  parameter logic [7:0]  MAX_LANE_COUNT    = 8'h84
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         REQ_Transaction_VLD,
  input  logic                         REQ_NATIVE_I2C,
  input  logic [1:0]                   REQ_CMD,
  input  logic [AUX_ADDRESS_WIDTH-1:0] REQ_Address,
  input  logic [AUX_DATA_WIDTH-1:0]    REQ_LEN,
  input  logic [AUX_DATA_WIDTH-1:0]    REQ_Data,
  input  logic                         Sink_Defer,
  input  logic [15:0]                  Lane_Status,
  input  logic [7:0]                   Lane_Align,
  output logic [1:0]                   Reply_ACK,
  output logic                         Reply_ACK_VLD,
  output logic [AUX_DATA_WIDTH-1:0]    Reply_Data,
  output logic                         Reply_Data_VLD,
  output logic                         Busy,
  output logic [7:0]                   Link_BW_Set,
  output logic [4:0]                   Lane_Count_Set,
  output logic [7:0]                   Training_Pattern
);

  typedef enum logic [2:0] {S_IDLE, S_WR_DATA, S_TURN, S_ACK, S_RD_DATA} state_e;

  state_e                          state_q;
  logic [1:0]                      cmd_q;
  region_e                         rgn_q;
  logic [3:0]                      ofs_q;
  logic [AUX_DATA_WIDTH-1:0]       len_q, cnt_q;
  logic                            defer_q, err_q, abort_q;
  logic [15:0][AUX_DATA_WIDTH-1:0] buf_q;
  reply_e                          ack_q;
  logic                            ack_vld_q, rvld_q, busy_q;
  logic [AUX_DATA_WIDTH-1:0]       rdata_q;

  region_e                         cap_rgn;
  logic [AUX_DATA_WIDTH:0]         cap_end;
  logic                            cap_err;
  logic                            wr_commit;
  logic [15:0][AUX_DATA_WIDTH-1:0] view;

  assign cap_rgn = decode_region(REQ_Address);
  assign cap_end = (AUX_DATA_WIDTH+1)'(REQ_Address[3:0]) + (AUX_DATA_WIDTH+1)'(REQ_LEN);
  assign cap_err = !REQ_NATIVE_I2C || REQ_CMD[1] || (REQ_LEN > AUX_DATA_WIDTH'(15)) ||
                   (cap_rgn == RGN_NONE) || (cap_end > (AUX_DATA_WIDTH+1)'(15));

  assign wr_commit = (state_q == S_ACK) && (cmd_q == CMD_WRITE) && (ack_q == REPLY_ACK);

  dp_dpcd_regfile #(
    .DPCD_REV       (DPCD_REV),
    .MAX_LINK_RATE  (MAX_LINK_RATE),
    .MAX_LANE_COUNT (MAX_LANE_COUNT)
  ) u_regfile (
    .clk                (clk),
    .rst                (rst),
    .rgn_i              (rgn_q),
    .wr_en_i            (wr_commit),
    .wr_ofs_i           (ofs_q),
    .wr_last_i          (len_q[3:0]),
    .wr_buf_i           (buf_q),
    .lane_status_i      (Lane_Status),
    .lane_align_i       (Lane_Align),
    .view_o             (view),
    .link_bw_o          (Link_BW_Set),
    .lane_count_o       (Lane_Count_Set),
    .training_pattern_o (Training_Pattern)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cmd_q     <= '0;
      rgn_q     <= RGN_NONE;
      ofs_q     <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      defer_q   <= 1'b0;
      err_q     <= 1'b0;
      abort_q   <= 1'b0;
      buf_q     <= '0;
      ack_q     <= REPLY_ACK;
      ack_vld_q <= 1'b0;
      rvld_q    <= 1'b0;
      rdata_q   <= '0;
      busy_q    <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: if (REQ_Transaction_VLD) begin
          cmd_q    <= REQ_CMD;
          rgn_q    <= cap_rgn;
          ofs_q    <= REQ_Address[3:0];
          len_q    <= REQ_LEN;
          defer_q  <= Sink_Defer;
          err_q    <= cap_err;
          abort_q  <= 1'b0;
          busy_q   <= 1'b1;
          buf_q[0] <= REQ_Data;
          if ((REQ_CMD == CMD_WRITE) && (REQ_LEN != '0)) begin
            cnt_q   <= AUX_DATA_WIDTH'(1);
            state_q <= S_WR_DATA;
          end else begin
            cnt_q   <= AUX_DATA_WIDTH'(REPLY_DELAY - 1);
            state_q <= S_TURN;
          end
        end
        // cnt_q counts bytes received so far; overlong bursts wrap but are NACKed anyway.
        S_WR_DATA: begin
          if (!REQ_Transaction_VLD) begin
            abort_q <= 1'b1;
            cnt_q   <= AUX_DATA_WIDTH'(REPLY_DELAY - 1);
            state_q <= S_TURN;
          end else begin
            buf_q[cnt_q[3:0]] <= REQ_Data;
            if (cnt_q == len_q) begin
              cnt_q   <= AUX_DATA_WIDTH'(REPLY_DELAY - 1);
              state_q <= S_TURN;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        S_TURN: begin
          if (cnt_q == '0) begin
            ack_vld_q <= 1'b1;
            ack_q     <= defer_q ? REPLY_DEFER : ((err_q || abort_q) ? REPLY_NACK : REPLY_ACK);
            state_q   <= S_ACK;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_ACK: begin
          ack_vld_q <= 1'b0;
          ack_q     <= REPLY_ACK;
          if ((cmd_q == CMD_READ) && (ack_q == REPLY_ACK)) begin
            for (int unsigned k = 0; k < 16; k++) buf_q[k] <= view[ofs_q + 4'(k)];
            rdata_q <= view[ofs_q];
            rvld_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= S_RD_DATA;
          end else begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_RD_DATA: begin
          if (cnt_q == len_q) begin
            rvld_q  <= 1'b0;
            rdata_q <= '0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            rdata_q <= buf_q[cnt_q[3:0] + 4'd1];
            cnt_q   <= cnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign Reply_ACK      = ack_q;
  assign Reply_ACK_VLD  = ack_vld_q;
  assign Reply_Data     = rdata_q;
  assign Reply_Data_VLD = rvld_q;
  assign Busy           = busy_q;

endmodule

// File: tb/tb_dp_sink_dpcd_responder.sv
// Directed bench for the DPCD sink responder; cycle 0 is the capture cycle.
module tb_dp_sink_dpcd_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        REQ_Transaction_VLD, REQ_NATIVE_I2C, Sink_Defer;
  logic [1:0]  REQ_CMD;
  logic [19:0] REQ_Address;
  logic [7:0]  REQ_LEN, REQ_Data, Lane_Align;
  logic [15:0] Lane_Status;
  logic [1:0]  Reply_ACK;
  logic        Reply_ACK_VLD, Reply_Data_VLD, Busy;
  logic [7:0]  Reply_Data, Link_BW_Set, Training_Pattern;
  logic [4:0]  Lane_Count_Set;

  int checks = 0;
  int errors = 0;

  logic [7:0] wdata [0:15];
  int         r_ack_cyc, r_ack_cnt, r_dcnt, r_dfirst, r_busy_fall;
  logic [1:0] r_ack_code;
  logic       r_busy1;
  logic [7:0] r_data [0:15];
  logic [7:0] r_bw_at_ack, r_bw_after, r_tp_after;
  logic [4:0] r_lc_after;

  dp_sink_dpcd_responder #(
    .AUX_ADDRESS_WIDTH (20),
    .AUX_DATA_WIDTH    (8),
    .REPLY_DELAY       (4),
    .DPCD_REV          (8'h12),
    .MAX_LINK_RATE     (8'h1E),
    .MAX_LANE_COUNT    (8'h84)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .REQ_Transaction_VLD (REQ_Transaction_VLD),
    .REQ_NATIVE_I2C      (REQ_NATIVE_I2C),
    .REQ_CMD             (REQ_CMD),
    .REQ_Address         (REQ_Address),
    .REQ_LEN             (REQ_LEN),
    .REQ_Data            (REQ_Data),
    .Sink_Defer          (Sink_Defer),
    .Lane_Status         (Lane_Status),
    .Lane_Align          (Lane_Align),
    .Reply_ACK           (Reply_ACK),
    .Reply_ACK_VLD       (Reply_ACK_VLD),
    .Reply_Data          (Reply_Data),
    .Reply_Data_VLD      (Reply_Data_VLD),
    .Busy                (Busy),
    .Link_BW_Set         (Link_BW_Set),
    .Lane_Count_Set      (Lane_Count_Set),
    .Training_Pattern    (Training_Pattern)
  );

  always #5 clk = ~clk;

  // Drives one request starting in the current (negedge) cycle and records the reply.
  // Returns at the negedge of the cycle where Busy falls, without driving that cycle.
  task automatic run_req(input logic [1:0] cmd, input logic [19:0] addr, input logic [7:0] len,
                         input int vld_n, input logic defer, input logic native);
    bit seen_busy = 1'b0;
    r_ack_cyc = -1; r_ack_cnt = 0; r_dcnt = 0; r_dfirst = -1; r_busy_fall = -1;
    r_ack_code = 2'b11; r_busy1 = 1'b0;
    r_bw_at_ack = 'x; r_bw_after = 'x; r_tp_after = 'x; r_lc_after = 'x;
    for (int c = 0; c <= 80; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 1) r_busy1 = Busy;
      if (Busy) seen_busy = 1'b1;
      if (Reply_ACK_VLD) begin
        r_ack_cnt++; r_ack_cyc = c; r_ack_code = Reply_ACK; r_bw_at_ack = Link_BW_Set;
      end
      if (Reply_Data_VLD) begin
        if (r_dcnt == 0) r_dfirst = c;
        if (r_dcnt < 16) r_data[r_dcnt] = Reply_Data;
        r_dcnt++;
      end
      if (r_ack_cyc >= 0 && c == r_ack_cyc + 1) begin
        r_bw_after = Link_BW_Set; r_lc_after = Lane_Count_Set; r_tp_after = Training_Pattern;
      end
      if (seen_busy && !Busy) begin
        r_busy_fall = c;
        break;
      end
      if (c == 80) begin
        checks++; errors++;
        $display("FAIL req_timeout got busy=%b after %0d cycles exp busy fall", Busy, c);
        break;
      end
      REQ_Transaction_VLD = (c < vld_n);
      REQ_Data            = (c < vld_n && c < 16) ? wdata[c] : 8'h00;
      REQ_CMD             = cmd;
      REQ_Address         = addr;
      REQ_LEN             = len;
      REQ_NATIVE_I2C      = native;
      Sink_Defer          = (c == 0) ? defer : 1'b0;
    end
    REQ_Transaction_VLD = 1'b0;
    Sink_Defer          = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({Reply_ACK, Reply_ACK_VLD, Reply_Data, Reply_Data_VLD, Busy} !== '0) begin
      errors++;
      $display("FAIL reset_reply got %b%b%h%b%b exp all zero", Reply_ACK, Reply_ACK_VLD, Reply_Data, Reply_Data_VLD, Busy);
    end
    checks++;
    if ({Link_BW_Set, Lane_Count_Set, Training_Pattern} !== '0) begin
      errors++;
      $display("FAIL reset_cfg got %h %h %h exp 00 00 00", Link_BW_Set, Lane_Count_Set, Training_Pattern);
    end
    rst = 1'b0;
  endtask

  task automatic test_write_cfg();
    wdata[0] = 8'h0A; wdata[1] = 8'h04;
    run_req(2'b00, 20'h00100, 8'd1, 2, 1'b0, 1'b1);
    checks++; if (r_busy1 !== 1'b1) begin errors++; $display("FAIL wr_busy_c1 got %b exp 1", r_busy1); end
    checks++; if (r_ack_cyc !== 6) begin errors++; $display("FAIL wr_ack_cycle got %0d exp 6", r_ack_cyc); end
    checks++; if (r_ack_code !== 2'b00) begin errors++; $display("FAIL wr_ack_code got %b exp 00", r_ack_code); end
    checks++; if (r_bw_at_ack !== 8'h00) begin errors++; $display("FAIL wr_bw_at_ack got %h exp 00", r_bw_at_ack); end
    checks++; if (r_bw_after !== 8'h0A) begin errors++; $display("FAIL wr_link_bw got %h exp 0a", r_bw_after); end
    checks++; if (r_lc_after !== 5'h04) begin errors++; $display("FAIL wr_lane_cnt got %h exp 04", r_lc_after); end
    checks++; if (r_tp_after !== 8'h00) begin errors++; $display("FAIL wr_tp got %h exp 00", r_tp_after); end
    checks++; if (r_busy_fall !== 7) begin errors++; $display("FAIL wr_busy_fall got %0d exp 7", r_busy_fall); end
    checks++; if (r_dcnt !== 0) begin errors++; $display("FAIL wr_no_data got %0d exp 0", r_dcnt); end
  endtask

  task automatic test_read_cap();
    run_req(2'b01, 20'h00000, 8'd2, 1, 1'b0, 1'b1);
    checks++; if (r_ack_cyc !== 5) begin errors++; $display("FAIL rd_ack_cycle got %0d exp 5", r_ack_cyc); end
    checks++; if (r_ack_code !== 2'b00) begin errors++; $display("FAIL rd_ack_code got %b exp 00", r_ack_code); end
    checks++; if (r_dcnt !== 3) begin errors++; $display("FAIL rd_data_count got %0d exp 3", r_dcnt); end
    checks++; if (r_dfirst !== 6) begin errors++; $display("FAIL rd_data_first got %0d exp 6", r_dfirst); end
    checks++;
    if ({r_data[0], r_data[1], r_data[2]} !== 24'h121E84) begin
      errors++; $display("FAIL rd_cap_bytes got %h %h %h exp 12 1e 84", r_data[0], r_data[1], r_data[2]);
    end
    checks++; if (r_busy_fall !== 9) begin errors++; $display("FAIL rd_busy_fall got %0d exp 9", r_busy_fall); end
  endtask

  task automatic test_read_cross();
    run_req(2'b01, 20'h0000E, 8'd3, 1, 1'b0, 1'b1);
    checks++; if (r_ack_code !== 2'b01) begin errors++; $display("FAIL cross_code got %b exp 01", r_ack_code); end
    checks++; if (r_ack_cyc !== 5) begin errors++; $display("FAIL cross_cycle got %0d exp 5", r_ack_cyc); end
    checks++; if (r_dcnt !== 0) begin errors++; $display("FAIL cross_no_data got %0d exp 0", r_dcnt); end
  endtask

  task automatic test_defer();
    wdata[0] = 8'h55;
    run_req(2'b00, 20'h00102, 8'd0, 1, 1'b1, 1'b1);
    checks++; if (r_ack_code !== 2'b10) begin errors++; $display("FAIL defer_code got %b exp 10", r_ack_code); end
    checks++; if (r_ack_cyc !== 5) begin errors++; $display("FAIL defer_cycle got %0d exp 5", r_ack_cyc); end
    checks++; if (r_tp_after !== 8'h00) begin errors++; $display("FAIL defer_tp got %h exp 00", r_tp_after); end
  endtask

  task automatic test_abort();
    wdata[0] = 8'h11; wdata[1] = 8'h22; wdata[2] = 8'h33; wdata[3] = 8'h44;
    run_req(2'b00, 20'h00100, 8'd3, 2, 1'b0, 1'b1);
    checks++; if (r_ack_code !== 2'b01) begin errors++; $display("FAIL abort_code got %b exp 01", r_ack_code); end
    checks++; if (r_ack_cyc !== 7) begin errors++; $display("FAIL abort_cycle got %0d exp 7", r_ack_cyc); end
    checks++;
    if ({r_bw_after, r_lc_after} !== {8'h0A, 5'h04}) begin
      errors++; $display("FAIL abort_cfg got %h %h exp 0a 04", r_bw_after, r_lc_after);
    end
  endtask

  task automatic test_status();
    Lane_Status = 16'hA55A; Lane_Align = 8'h81;
    run_req(2'b01, 20'h00202, 8'd2, 1, 1'b0, 1'b1);
    checks++;
    if ({r_dcnt[7:0], r_data[0], r_data[1], r_data[2]} !== 32'h035AA581) begin
      errors++; $display("FAIL status_bytes got n=%0d %h %h %h exp n=3 5a a5 81", r_dcnt, r_data[0], r_data[1], r_data[2]);
    end
    run_req(2'b01, 20'h00100, 8'd1, 1, 1'b0, 1'b1);
    checks++;
    if ({r_ack_code, r_data[0], r_data[1]} !== {2'b00, 8'h0A, 8'h04}) begin
      errors++; $display("FAIL cfg_readback got %b %h %h exp 00 0a 04", r_ack_code, r_data[0], r_data[1]);
    end
  endtask

  task automatic test_nack_misc();
    run_req(2'b01, 20'h00000, 8'd0, 1, 1'b0, 1'b0);
    checks++; if ({r_ack_code, r_dcnt[7:0]} !== {2'b01, 8'd0}) begin errors++; $display("FAIL i2c_nack got %b n=%0d exp 01 n=0", r_ack_code, r_dcnt); end
    run_req(2'b10, 20'h00100, 8'd0, 1, 1'b0, 1'b1);
    checks++; if (r_ack_code !== 2'b01) begin errors++; $display("FAIL rsvd_cmd_nack got %b exp 01", r_ack_code); end
    run_req(2'b01, 20'h00000, 8'd16, 1, 1'b0, 1'b1);
    checks++; if ({r_ack_code, r_dcnt[7:0]} !== {2'b01, 8'd0}) begin errors++; $display("FAIL len16_nack got %b n=%0d exp 01 n=0", r_ack_code, r_dcnt); end
    wdata[0] = 8'hFF;
    run_req(2'b00, 20'h00000, 8'd0, 1, 1'b0, 1'b1);
    checks++; if (r_ack_code !== 2'b00) begin errors++; $display("FAIL ro_write_ack got %b exp 00", r_ack_code); end
    run_req(2'b01, 20'h00000, 8'd0, 1, 1'b0, 1'b1);
    checks++; if (r_data[0] !== 8'h12) begin errors++; $display("FAIL ro_unchanged got %h exp 12", r_data[0]); end
  endtask

  task automatic test_back_to_back();
    run_req(2'b01, 20'h00001, 8'd0, 1, 1'b0, 1'b1);
    checks++; if ({r_data[0], r_busy_fall[7:0]} !== {8'h1E, 8'd7}) begin errors++; $display("FAIL b2b_first got %h fall=%0d exp 1e fall=7", r_data[0], r_busy_fall); end
    wdata[0] = 8'h07;
    run_req(2'b00, 20'h00102, 8'd0, 1, 1'b0, 1'b1);
    checks++; if (r_ack_cyc !== 5) begin errors++; $display("FAIL b2b_ack_cycle got %0d exp 5", r_ack_cyc); end
    checks++; if (r_tp_after !== 8'h07) begin errors++; $display("FAIL b2b_tp got %h exp 07", r_tp_after); end
  endtask

  task automatic test_max_burst();
    for (int i = 0; i < 16; i++) wdata[i] = 8'h30 + 8'(i);
    run_req(2'b00, 20'h00100, 8'd15, 16, 1'b0, 1'b1);
    checks++; if (r_ack_cyc !== 20) begin errors++; $display("FAIL max_ack_cycle got %0d exp 20", r_ack_cyc); end
    checks++;
    if ({r_bw_after, r_lc_after, r_tp_after} !== {8'h30, 5'h11, 8'h32}) begin
      errors++; $display("FAIL max_cfg got %h %h %h exp 30 11 32", r_bw_after, r_lc_after, r_tp_after);
    end
    run_req(2'b01, 20'h0010F, 8'd0, 1, 1'b0, 1'b1);
    checks++; if (r_data[0] !== 8'h3F) begin errors++; $display("FAIL max_last_byte got %h exp 3f", r_data[0]); end
  endtask

  task automatic test_reset_midread();
    bit seen = 1'b0;
    REQ_CMD = 2'b01; REQ_Address = 20'h00000; REQ_LEN = 8'd2; REQ_NATIVE_I2C = 1'b1;
    REQ_Transaction_VLD = 1'b1;
    @(negedge clk);
    REQ_Transaction_VLD = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (Reply_Data_VLD) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL midread_data_seen got %b exp 1", seen); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({Reply_ACK, Reply_ACK_VLD, Reply_Data, Reply_Data_VLD, Busy, Link_BW_Set, Lane_Count_Set, Training_Pattern} !== '0) begin
      errors++; $display("FAIL midread_reset got ack=%b v=%b d=%h dv=%b busy=%b cfg=%h %h %h exp all zero",
                         Reply_ACK, Reply_ACK_VLD, Reply_Data, Reply_Data_VLD, Busy, Link_BW_Set, Lane_Count_Set, Training_Pattern);
    end
    run_req(2'b01, 20'h00101, 8'd0, 1, 1'b0, 1'b1);
    checks++;
    if ({r_ack_code, r_dcnt[7:0], r_data[0]} !== {2'b00, 8'd1, 8'h00}) begin
      errors++; $display("FAIL post_reset_101 got %b n=%0d %h exp 00 n=1 00", r_ack_code, r_dcnt, r_data[0]);
    end
  endtask

  initial begin
    rst = 1'b1;
    REQ_Transaction_VLD = 1'b0; REQ_NATIVE_I2C = 1'b1; REQ_CMD = 2'b00;
    REQ_Address = '0; REQ_LEN = '0; REQ_Data = '0; Sink_Defer = 1'b0;
    Lane_Status = '0; Lane_Align = '0;
    for (int i = 0; i < 16; i++) begin wdata[i] = 8'h00; r_data[i] = 8'h00; end
    test_reset();
    test_write_cfg();
    test_read_cap();
    test_read_cross();
    test_defer();
    test_abort();
    test_status();
    test_nack_misc();
    test_back_to_back();
    test_max_burst();
    test_reset_midread();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dp_sink_dpcd_responder.md
# dp_sink_dpcd_responder

Sink-side responder for the transaction-layer native AUX request stream issued by the source's SPM/LPM. It is the bench-side and silicon-side counterpart of the source transaction layer. It captures a native read or write request, executes it against a small DPCD register file (capability, link configuration and status regions), and returns an ACK/NACK/DEFER reply, plus read data byte-by-byte after a programmable turnaround.

## Interface
- AUX_ADDRESS_WIDTH, 20, DPCD address width
- AUX_DATA_WIDTH, 8, byte width of data and LEN
- REPLY_DELAY, 4, turnaround cycles between end of request and reply (≥1)
- DPCD_REV, 8'h12, value of DPCD 00000h
- MAX_LINK_RATE, 8'h1E, value of 00001h
- MAX_LANE_COUNT, 8'h84, value of 00002h

Ports:
- clk  in  1  single clock
- rst  in  1  reset; **synchronous, active-high**
- REQ_Transaction_VLD  in  1  request valid (held for LEN+1 cycles on writes)
- REQ_NATIVE_I2C  in  1  1 = native, 0 = I2C-over-AUX
- REQ_CMD  in  2  2'b00 write, 2'b01 read, 2'b1x reserved
- REQ_Address  in  AUX_ADDRESS_WIDTH  start address
- REQ_LEN  in  AUX_DATA_WIDTH  byte count minus 1
- REQ_Data  in  AUX_DATA_WIDTH  write byte, one per valid cycle
- Sink_Defer  in  1  when high at capture, the reply is DEFER
- Lane_Status  in  16  mirrored at 00202h (low byte) and 00203h
- Lane_Align  in  8  mirrored at 00204h
- Reply_ACK  out  2  2'b00 ACK, 2'b01 NACK, 2'b10 DEFER
- Reply_ACK_VLD  out  1  one-cycle pulse with Reply_ACK
- Reply_Data  out  AUX_DATA_WIDTH  read byte
- Reply_Data_VLD  out  1  high for LEN+1 consecutive cycles on read ACK
- Busy  out  1  high from capture through the last reply cycle
- Link_BW_Set  out  8  register 00100h
- Lane_Count_Set  out  5  register 00101h[4:0]
- Training_Pattern  out  8  register 00102h

## Operation
- Register map:
  - 00000h–0000Fh capability: read-only; bytes 0–2 come from parameters, the rest read 0.
  - 00100h–0010Fh link config: read/write; reset to 0.
  - 00200h–0020Fh status: read-only; 202h/203h/204h come from inputs, the rest read 0.
- Writes to a read-only region are ACKed and the data is discarded.
- A request is NACKed (no register change, no data) if any of the following holds:
  - REQ_NATIVE_I2C = 0;
  - REQ_CMD is reserved;
  - LEN > 15;
  - the burst lies outside a single region (including partially).
- DEFER takes priority over all checks. Sink_Defer is sampled at the capture cycle.
- FSM states: IDLE → (VLD & write) WR_DATA / (VLD & other) TURN → ACK → (read ACK) RD_DATA → IDLE; otherwise ACK → IDLE.
- WR_DATA collects bytes into a 16-byte buffer. Address, CMD and LEN are latched at capture.
- If VLD drops before LEN+1 bytes have arrived, the write is aborted: the FSM goes to TURN and the reply is NACK.
- A write commits atomically to the register file in the ACK cycle, and only when the reply is ACK.
- Read data is snapshotted from the register file into the buffer in the ACK cycle.
- VLD while Busy (outside WR_DATA) is ignored; no queueing.

## Timing
- Reset: all outputs 0, FSM IDLE, config registers 0.
- Reset is honoured from any state and aborts in-flight transactions without a reply.
- Cycle 0 is the capture cycle (VLD high in IDLE). Busy rises in cycle 1.
- Write: data occupies cycles 0..LEN, TURN lasts REPLY_DELAY cycles, and Reply_ACK_VLD fires at cycle LEN+REPLY_DELAY+1.
- Read / NACK / DEFER: Reply_ACK_VLD fires at cycle REPLY_DELAY+1.
- Read ACK: Reply_Data_VLD covers cycles REPLY_DELAY+2 .. REPLY_DELAY+LEN+2, with byte k at address+k.
- Busy falls the cycle after the last reply cycle. A new request can be captured in that same cycle.
- Link_BW_Set, Lane_Count_Set and Training_Pattern update the cycle after the committing ACK.

## Structure
- Shared package dp_tl_pkg holds:
  - AUX_ADDRESS_WIDTH and AUX_DATA_WIDTH;
  - the reply-code enum (ACK/NACK/DEFER);
  - the command enum;
  - the region base addresses.
- Sub-module dp_dpcd_regfile holds the map decode, the read-only/read-write arrays and the input mirroring. The top level holds the FSM, buffer and counters.

## Test plan
- Write 00100h, LEN=1, data 0A,04 → ACK at cycle 6; Link_BW_Set=0A and Lane_Count_Set=04 at cycle 7.
- Read 00000h, LEN=2 → ACK at cycle 5; data 12,1E,84 on cycles 6–8; Busy low at cycle 9.
- Read 0000Eh, LEN=3 (crosses region end) → NACK, no Reply_Data_VLD.
- Sink_Defer=1 on a write to 00102h → DEFER; Training_Pattern stays 0.
- Write to 00100h, LEN=3, with VLD dropped after 2 bytes → NACK; config registers unchanged.
- Assert rst during RD_DATA → all outputs 0 next cycle; the next read of 00101h returns 00.
